// File: rtl/mem_lock_pkg.sv
// Shared types and sizes for the memory/lock arbiter.
package mem_lock_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned NLOCK   = 16;
  localparam int unsigned LOCK_AW = 4;
  localparam int unsigned CORE_W  = 2;

  typedef struct packed {
    logic              held;
    logic [CORE_W-1:0] owner;
  } lock_entry_t;

endpackage

// File: rtl/mem_lock_arbiter_lock_table.sv
// Hardware lock table: per-core lock/unlock acknowledge with lowest-index priority.
module lock_table
  import mem_lock_pkg::*;
#(
  parameter int unsigned NCORE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LOCK_AW*NCORE-1:0] lock_adr,
  input  logic [NCORE-1:0]         lock_en,
  input  logic [NCORE-1:0]         unlock_en,
  output logic [NCORE-1:0]         lock_ac
);

  lock_entry_t        r_table     [NLOCK];
  lock_entry_t        w_table_nxt [NLOCK];
  logic [NLOCK-1:0]   w_claimed;
  logic [LOCK_AW-1:0] w_adr       [NCORE];

  for (genvar g = 0; g < int'(NCORE); g++) begin : g_adr
    assign w_adr[g] = lock_adr[LOCK_AW*g +: LOCK_AW];
  end

  // Decisions use the pre-edge table; w_claimed resolves same-cycle lockers by core index.
  always_comb begin
    w_table_nxt = r_table;
    w_claimed   = '0;
    lock_ac     = '0;
    for (int i = 0; i < int'(NCORE); i++) begin
      if (unlock_en[i]) begin
        lock_ac[i] = 1'b1;
        if (r_table[w_adr[i]].held && (r_table[w_adr[i]].owner == CORE_W'(i))) begin
          w_table_nxt[w_adr[i]] = '0;
        end
      end else if (lock_en[i]) begin
        if ((!r_table[w_adr[i]].held || (r_table[w_adr[i]].owner == CORE_W'(i)))
            && !w_claimed[w_adr[i]]) begin
          lock_ac[i]            = 1'b1;
          w_claimed[w_adr[i]]   = 1'b1;
          w_table_nxt[w_adr[i]] = '{held: 1'b1, owner: CORE_W'(i)};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NLOCK); k++) begin
        r_table[k] <= '0;
      end
    end else begin
      r_table <= w_table_nxt;
    end
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Round-robin fixed-latency main-memory arbiter plus hardware lock table for NCORE cores.
module mem_lock_arbiter
  import mem_lock_pkg::*;
#(
  parameter int unsigned NCORE   = 2,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORE-1:0]         mem_read_req,
  input  logic [NCORE-1:0]         mem_write_req,
  input  logic [LOCK_AW*NCORE-1:0] lock_adr,
  input  logic [NCORE-1:0]         lock_en,
  input  logic [NCORE-1:0]         unlock_en,
  output logic [NCORE-1:0]         main_mem_ac,
  output logic [NCORE-1:0]         lock_ac,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [1:0]               mem_sel
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned NSLOT = 1 << CORE_W;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CORE_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [CORE_W-1:0] r_mem_sel, w_sel_nxt;
  logic              r_mem_en, w_en_nxt;
  logic              r_mem_we, w_we_nxt;
  logic [NCORE-1:0]  r_ac;
  logic [NSLOT-1:0]  w_ac_nxt;
  logic [NSLOT-1:0]  w_req;
  logic [NSLOT-1:0]  w_wr;
  logic [CORE_W-1:0] w_idx;
  logic [CORE_W-1:0] w_cand;
  logic              w_found;

  // Padded to the full index space so core-index selects are exact width.
  assign w_req = NSLOT'(mem_read_req | mem_write_req);
  assign w_wr  = NSLOT'(mem_write_req);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_ptr;
    w_sel_nxt   = r_mem_sel;
    w_en_nxt    = r_mem_en;
    w_we_nxt    = r_mem_we;
    w_ac_nxt    = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    w_cand      = '0;
    case (r_state)
      IDLE: begin
        w_en_nxt = 1'b0;
        for (int k = 0; k < int'(NCORE); k++) begin
          w_cand = CORE_W'((int'(r_rr_ptr) + k) % int'(NCORE));
          if (!w_found && w_req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
          end
        end
        if (w_found) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = w_idx;
          w_we_nxt    = w_wr[w_idx];
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_ac_nxt[r_mem_sel] = 1'b1;
          w_en_nxt            = 1'b0;
          w_rr_nxt            = (r_mem_sel == CORE_W'(NCORE - 1)) ? '0 : r_mem_sel + CORE_W'(1);
          w_state_nxt         = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rr_ptr  <= '0;
      r_mem_sel <= '0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_ac      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_mem_sel <= w_sel_nxt;
      r_mem_en  <= w_en_nxt;
      r_mem_we  <= w_we_nxt;
      r_ac      <= NCORE'(w_ac_nxt);
    end
  end

  assign main_mem_ac = r_ac;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_sel     = r_mem_sel;

  lock_table #(.NCORE(NCORE)) u_lock_table (
    .clk       (clk),
    .reset     (reset),
    .lock_adr  (lock_adr),
    .lock_en   (lock_en),
    .unlock_en (unlock_en),
    .lock_ac   (lock_ac)
  );

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Scoreboard bench for mem_lock_arbiter: expected ac pulses queued at drive time, lock_ac checked directly.
module tb_mem_lock_arbiter;

  localparam int unsigned NCORE   = 2;
  localparam int unsigned MEM_LAT = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NCORE-1:0]   mem_read_req, mem_write_req, lock_en, unlock_en;
  logic [4*NCORE-1:0] lock_adr;
  logic [NCORE-1:0]   main_mem_ac, lock_ac;
  logic               mem_en, mem_we;
  logic [1:0]         mem_sel;

  mem_lock_arbiter #(.NCORE(NCORE), .MEM_LAT(MEM_LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .lock_adr      (lock_adr),
    .lock_en       (lock_en),
    .unlock_en     (unlock_en),
    .main_mem_ac   (main_mem_ac),
    .lock_ac       (lock_ac),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_sel       (mem_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCORE-1:0] mask;
    int               at;
  } ac_exp_t;

  ac_exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int g;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic expect_ac(input logic [NCORE-1:0] mask, input int at);
    ac_exp_t e;
    e.mask = mask;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare any completion pulse against the scoreboard head.
  task automatic tick();
    ac_exp_t e;
    @(posedge clk);
    #1;
    if (main_mem_ac != '0) begin
      if (sb.size() == 0) begin
        check("ac_unexpected", int'(main_mem_ac), 0);
      end else begin
        e = sb.pop_front();
        check("ac_mask", int'(main_mem_ac), int'(e.mask));
        check("ac_cycle", cyc, e.at);
      end
    end
  endtask

  task automatic check_port(input string tag, input int en, input int we, input int sel);
    check({tag, "_en"}, int'(mem_en), en);
    check({tag, "_we"}, int'(mem_we), we);
    check({tag, "_sel"}, int'(mem_sel), sel);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    mem_read_req  = '0;
    mem_write_req = '0;
    lock_en       = '0;
    unlock_en     = '0;
    lock_adr      = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check_port("rst", 0, 0, 0);
    check("rst_ac", int'(main_mem_ac), 0);
    check("rst_lock_ac", int'(lock_ac), 0);

    // Single read from core0.
    mem_read_req = 2'b01;
    expect_ac(2'b01, cyc + 1 + MEM_LAT);
    tick(); check_port("t1_c1", 1, 0, 0);
    tick(); check_port("t1_c2", 1, 0, 0);
    tick(); check("t1_en_off", int'(mem_en), 0);
    mem_read_req = '0;
    tick();
    check("t1_ac_clear", int'(main_mem_ac), 0);
    check("t1_idle", int'(mem_en), 0);

    // Continuous writes from both cores alternate with MEM_LAT+1 spacing.
    do_reset();
    g = cyc;
    mem_write_req = 2'b11;
    for (int j = 0; j < 4; j++)
      expect_ac(NCORE'(1 << (j % 2)), g + 1 + MEM_LAT + j * (MEM_LAT + 1));
    for (int t = 1; t <= 4 * (MEM_LAT + 1); t++) begin
      tick();
      if (((t - 1) % (MEM_LAT + 1)) < MEM_LAT)
        check_port("t2", 1, 1, ((t - 1) / (MEM_LAT + 1)) % 2);
      else
        check("t2_gap", int'(mem_en), 0);
    end
    mem_write_req = '0;
    tick(); check("t2_idle", int'(mem_en), 0);

    // Core1 drops its request after grant; completion still fires, core0 follows.
    do_reset();
    mem_write_req = 2'b10;
    expect_ac(2'b10, cyc + 1 + MEM_LAT);
    tick(); check_port("t3_g", 1, 1, 1);
    mem_write_req = '0;
    mem_read_req  = 2'b01;
    tick(); check_port("t3_g1", 1, 1, 1);
    tick(); check("t3_ac_idle", int'(mem_en), 0);
    expect_ac(2'b01, cyc + 1 + MEM_LAT);
    tick(); check_port("t3_next", 1, 0, 0);
    tick();
    tick();
    mem_read_req = '0;
    tick(); check("t3_idle", int'(mem_en), 0);

    // Simultaneous lock on a free address: lowest core wins.
    do_reset();
    lock_adr = {4'd5, 4'd5};
    lock_en  = 2'b11;
    #1 check("t4_both", int'(lock_ac), 1);
    tick();
    lock_en = 2'b10;
    #1 check("t4_retry", int'(lock_ac), 0);
    lock_en = 2'b11;
    #1 check("t4_relock", int'(lock_ac), 1);
    tick();

    // Owner unlock races another core's lock; locker wins one cycle later.
    lock_en   = 2'b10;
    unlock_en = 2'b01;
    #1 check("t5_same", int'(lock_ac), 1);
    tick();
    unlock_en = '0;
    lock_en   = 2'b10;
    #1 check("t5_grant1", int'(lock_ac), 2);
    tick();
    lock_en   = '0;
    unlock_en = 2'b01;
    #1 check("t5_nonowner_unlock", int'(lock_ac), 1);
    tick();
    unlock_en = '0;
    lock_en   = 2'b01;
    #1 check("t5_still_held", int'(lock_ac), 0);
    lock_en   = 2'b10;
    unlock_en = 2'b10;
    #1 check("t5_lock_unlock", int'(lock_ac), 2);
    tick();
    unlock_en = '0;
    lock_en   = 2'b01;
    #1 check("t5_freed", int'(lock_ac), 1);
    tick();
    lock_adr = {4'd15, 4'd0};
    lock_en  = 2'b11;
    #1 check("t5_edge_adrs", int'(lock_ac), 3);
    tick();
    lock_en = '0;

    // Reset during BUSY with lock 3 held: no completion, table cleared.
    lock_adr = {4'd0, 4'd3};
    lock_en  = 2'b01;
    #1 check("t6_lock3", int'(lock_ac), 1);
    tick();
    lock_en      = '0;
    mem_read_req = 2'b01;
    tick(); check("t6_busy", int'(mem_en), 1);
    reset        = 1'b1;
    mem_read_req = '0;
    tick();
    check("t6_rst_en", int'(mem_en), 0);
    check("t6_rst_ac", int'(main_mem_ac), 0);
    reset    = 1'b0;
    lock_adr = {4'd3, 4'd0};
    lock_en  = 2'b10;
    #1 check("t6_free3", int'(lock_ac), 2);
    tick();
    lock_en      = '0;
    mem_read_req = 2'b01;
    expect_ac(2'b01, cyc + 1 + MEM_LAT);
    tick(); check_port("t6_regrant", 1, 0, 0);
    tick();
    tick();
    mem_read_req = '0;
    tick();
    tick();

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
